adc_scan: RTL and testbench

ADC_SCAN -- requirements
Module: adc_scan

---
 rtl/adc_scan.sv | 172 +++++++++++++++++
 tb/tb_adc_scan.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan.sv
// Round-robin scanner for 17 ADC channels spread over three SPI ADC chips.
// Each frame sends a single-ended channel command, then shifts a 10-bit result into adc_<ch>_val.
module adc_scan #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 8
) (
    input  logic       SYS_CLK,
    input  logic       SYS_RST_N,
    input  logic       scan_en,
    output logic [2:0] ADC_CS_N,
    output logic       ADC_SCLK,
    output logic       ADC_MOSI,
    input  logic       ADC_MISO,
    output logic [9:0] adc_0_val,
    output logic [9:0] adc_1_val,
    output logic [9:0] adc_2_val,
    output logic [9:0] adc_3_val,
    output logic [9:0] adc_4_val,
    output logic [9:0] adc_5_val,
    output logic [9:0] adc_6_val,
    output logic [9:0] adc_7_val,
    output logic [9:0] adc_8_val,
    output logic [9:0] adc_9_val,
    output logic [9:0] adc_10_val,
    output logic [9:0] adc_11_val,
    output logic [9:0] adc_12_val,
    output logic [9:0] adc_13_val,
    output logic [9:0] adc_14_val,
    output logic [9:0] adc_15_val,
    output logic [9:0] adc_16_val,
    output logic       scan_done
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [5:0]  half;
    logic [4:0]  ch;
    logic [4:0]  ch_next;
    logic [4:0]  period;
    logic [9:0]  data;
    logic [1:0]  miso_sync;
    logic [9:0]  val [17];

    function automatic logic [2:0] cs_sel(input logic [4:0] c);
        if (c >= 5'd16)     return 3'b011;
        else if (c >= 5'd8) return 3'b101;
        else                return 3'b110;
    endfunction

    function automatic logic cmd_bit(input logic [4:0] p, input logic [4:0] c);
        case (p)
            5'd1, 5'd2: return 1'b1;
            5'd3:       return c[2];
            5'd4:       return c[1];
            5'd5:       return c[0];
            default:    return 1'b0;
        endcase
    endfunction

    assign ch_next = (ch == 5'd16) ? '0 : ch + 5'd1;
    // Even half-periods are SCLK low, odd ones high; both belong to period half/2+1.
    assign period  = half[5:1] + 5'd1;

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state     <= IDLE;
            cnt       <= '0;
            half      <= '0;
            ch        <= '0;
            data      <= '0;
            miso_sync <= '0;
            ADC_CS_N  <= '1;
            ADC_SCLK  <= 1'b0;
            ADC_MOSI  <= 1'b0;
            scan_done <= 1'b0;
            for (int unsigned i = 0; i < 17; i++) val[i] <= '0;
        end else begin
            scan_done <= 1'b0;
            miso_sync <= {miso_sync[0], ADC_MISO};
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state    <= SETUP;
                        cnt      <= '0;
                        ADC_CS_N <= cs_sel(ch);
                        ADC_MOSI <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == DIV_LAST) begin
                        state <= SHIFT;
                        cnt   <= '0;
                        half  <= '0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                SHIFT: begin
                    // Command bit for periods 2..17 changes one cycle after the SCLK fall.
                    if (!half[0] && cnt == '0 && half != '0)
                        ADC_MOSI <= cmd_bit(period, ch);
                    if (cnt == DIV_LAST) begin
                        cnt <= '0;
                        if (half[0] && period >= 5'd8)
                            data <= {data[8:0], miso_sync[1]};
                        if (half == 6'd33) begin
                            state    <= HOLD;
                            ADC_SCLK <= 1'b0;
                        end else begin
                            half     <= half + 6'd1;
                            ADC_SCLK <= ~ADC_SCLK;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt == DIV_LAST) begin
                        state     <= GAP;
                        cnt       <= '0;
                        ADC_CS_N  <= '1;
                        ADC_MOSI  <= 1'b0;
                        val[ch]   <= data;
                        scan_done <= (ch == 5'd16);
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_LAST) begin
                        cnt <= '0;
                        ch  <= ch_next;
                        if (scan_en) begin
                            state    <= SETUP;
                            ADC_CS_N <= cs_sel(ch_next);
                            ADC_MOSI <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign adc_0_val  = val[0];
    assign adc_1_val  = val[1];
    assign adc_2_val  = val[2];
    assign adc_3_val  = val[3];
    assign adc_4_val  = val[4];
    assign adc_5_val  = val[5];
    assign adc_6_val  = val[6];
    assign adc_7_val  = val[7];
    assign adc_8_val  = val[8];
    assign adc_9_val  = val[9];
    assign adc_10_val = val[10];
    assign adc_11_val = val[11];
    assign adc_12_val = val[12];
    assign adc_13_val = val[13];
    assign adc_14_val = val[14];
    assign adc_15_val = val[15];
    assign adc_16_val = val[16];

endmodule

// File: tb/tb_adc_scan.sv
// Directed bench for adc_scan: behavioural ADC chip model plus protocol monitors.
module tb_adc_scan;

    logic       SYS_CLK;
    logic       SYS_RST_N;
    logic       scan_en;
    logic [2:0] ADC_CS_N;
    logic       ADC_SCLK;
    logic       ADC_MOSI;
    logic       ADC_MISO;
    logic       scan_done;
    logic [9:0] vals [17];

    adc_scan #(.CLK_DIV(4), .CS_GAP(8)) dut (
        .SYS_CLK    (SYS_CLK),
        .SYS_RST_N  (SYS_RST_N),
        .scan_en    (scan_en),
        .ADC_CS_N   (ADC_CS_N),
        .ADC_SCLK   (ADC_SCLK),
        .ADC_MOSI   (ADC_MOSI),
        .ADC_MISO   (ADC_MISO),
        .adc_0_val  (vals[0]),
        .adc_1_val  (vals[1]),
        .adc_2_val  (vals[2]),
        .adc_3_val  (vals[3]),
        .adc_4_val  (vals[4]),
        .adc_5_val  (vals[5]),
        .adc_6_val  (vals[6]),
        .adc_7_val  (vals[7]),
        .adc_8_val  (vals[8]),
        .adc_9_val  (vals[9]),
        .adc_10_val (vals[10]),
        .adc_11_val (vals[11]),
        .adc_12_val (vals[12]),
        .adc_13_val (vals[13]),
        .adc_14_val (vals[14]),
        .adc_15_val (vals[15]),
        .adc_16_val (vals[16]),
        .scan_done  (scan_done)
    );

    initial begin
        SYS_CLK = 1'b0;
        forever #5 SYS_CLK = ~SYS_CLK;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ADC model state and frame log
    int         mode = 0;
    int         cyc = 0;
    bit         in_frame = 0;
    bit         end_flag = 0;
    logic [2:0] cur_cs = 3'b111;
    logic [4:0] cmd = '0;
    int         falls = 0, rises = 0, low_len = 0;
    int         t_start = 0, t_prev_start = -1, t_last_fall = 0;
    int         last_period = 0, n_cs_fall = 0;
    logic [2:0] last_cs = 3'b111;
    logic [4:0] last_cmd = '0;
    int         last_low = 0, last_rises = 0, last_span = 0;
    int         viol_mosi = 0, viol_cs = 0, viol_val = 0, viol_done = 0, done_cnt = 0;

    function automatic logic [9:0] model_val(input int c);
        if (mode == 0 && c == 0) return 10'h2A5;
        if (mode == 2) return 10'(10 * c + 7);
        return 10'(10 * c + 3);
    endfunction

    function automatic int chip_of(input logic [2:0] cs);
        case (cs)
            3'b110:  return 0;
            3'b101:  return 1;
            3'b011:  return 2;
            default: return 3;
        endcase
    endfunction

    initial begin : model
        logic [2:0] pcs;
        logic       psclk, pmosi, prst;
        logic [9:0] pvals [17];
        logic [9:0] v;
        int         p, zeros;
        bit         changed, gap_entry;
        pcs = 3'b111; psclk = 0; pmosi = 0; prst = 0;
        for (int i = 0; i < 17; i++) pvals[i] = '0;
        forever begin
            @(negedge SYS_CLK);
            cyc++;
            end_flag = 0;
            gap_entry = (ADC_CS_N == 3'b111 && pcs != 3'b111);
            if (ADC_CS_N != 3'b111 && pcs == 3'b111) begin
                in_frame = 1; cur_cs = ADC_CS_N; falls = 0; rises = 0; cmd = '0; low_len = 0;
                t_start = cyc;
                if (t_prev_start >= 0) last_period = cyc - t_prev_start;
                t_prev_start = cyc;
                n_cs_fall++;
                ADC_MISO = 1'b1;
            end
            if (in_frame && ADC_CS_N != 3'b111) low_len++;
            if (ADC_SCLK && !psclk) begin
                rises++;
                if (rises <= 5) cmd = {cmd[3:0], ADC_MOSI};
            end
            if (!ADC_SCLK && psclk) begin
                falls++;
                t_last_fall = cyc;
                p = falls + 1;
                v = model_val(chip_of(cur_cs) * 8 + int'(cmd[2:0]));
                ADC_MISO = (p >= 8 && p <= 17) ? v[17 - p] : 1'b1;
            end
            if (gap_entry) begin
                in_frame = 0; end_flag = 1;
                last_cs = cur_cs; last_cmd = cmd; last_low = low_len; last_rises = rises;
                last_span = t_last_fall - t_start;
            end
            if (ADC_SCLK && psclk && ADC_MOSI != pmosi) viol_mosi++;
            zeros = 0;
            for (int i = 0; i < 3; i++) if (!ADC_CS_N[i]) zeros++;
            if (zeros > 1) viol_cs++;
            changed = 0;
            for (int i = 0; i < 17; i++) begin
                if (vals[i] != pvals[i]) changed = 1;
                pvals[i] = vals[i];
            end
            if (changed && !gap_entry && SYS_RST_N && prst) viol_val++;
            if (scan_done) begin
                done_cnt++;
                if (!gap_entry) viol_done++;
            end
            pcs = ADC_CS_N; psclk = ADC_SCLK; pmosi = ADC_MOSI; prst = SYS_RST_N;
        end
    end

    task automatic wait_frame_end(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge SYS_CLK); #1;
            if (end_flag) seen = 1;
        end
        if (!seen) check("frame_end_timeout", 0, 1);
    endtask

    task automatic wait_falls(input int n, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge SYS_CLK); #1;
            if (in_frame && falls == n) seen = 1;
        end
        if (!seen) check("sclk_fall_timeout", 0, 1);
    endtask

    initial begin : stim
        int falls_before;
        SYS_RST_N = 1'b0;
        scan_en   = 1'b0;
        ADC_MISO  = 1'b0;
        repeat (5) @(negedge SYS_CLK);
        #1;
        check("rst_cs_n", 32'(ADC_CS_N), 32'h7);
        check("rst_sclk", 32'(ADC_SCLK), 0);
        check("rst_mosi", 32'(ADC_MOSI), 0);
        check("rst_adc0", 32'(vals[0]), 0);
        check("rst_adc16", 32'(vals[16]), 0);
        check("rst_done", 32'(scan_done), 0);

        @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        repeat (20) @(negedge SYS_CLK);
        #1;
        check("idle_cs_n", 32'(ADC_CS_N), 32'h7);
        check("idle_no_frame", 32'(n_cs_fall), 0);

        // Channel 0 with the fixed 2A5 pattern
        scan_en = 1'b1;
        wait_frame_end(400);
        check("ch0_cs", 32'(last_cs), 32'h6);
        check("ch0_cmd", 32'(last_cmd), 32'h18);
        check("ch0_cs_low_len", 32'(last_low), 144);
        check("ch0_cs_to_last_fall", 32'(last_span), 140);
        check("ch0_sclk_periods", 32'(last_rises), 17);
        check("ch0_val", 32'(vals[0]), 32'h2A5);
        check("ch0_done", 32'(scan_done), 0);

        // Full scan ch1..ch16 and wrap back to ch0 with value 10*ch+3
        mode = 1;
        for (int f = 1; f <= 17; f++) begin
            wait_frame_end(400);
            if (f == 9) begin
                check("ch9_cs", 32'(last_cs), 32'h5);
                check("ch9_cmd", 32'(last_cmd), 32'h19);
            end
            if (f == 16) begin
                check("ch16_cs", 32'(last_cs), 32'h3);
                check("ch16_cmd", 32'(last_cmd), 32'h18);
                check("ch16_done", 32'(scan_done), 1);
            end
            if (f == 17) begin
                check("wrap_cs", 32'(last_cs), 32'h6);
                check("wrap_cmd", 32'(last_cmd), 32'h18);
                check("frame_period", 32'(last_period), 152);
            end
        end
        for (int i = 0; i < 17; i++) check($sformatf("scan_val%0d", i), 32'(vals[i]), 32'(10 * i + 3));
        check("done_pulses", 32'(done_cnt), 1);

        // scan_en dropped during period 3 of ch5
        repeat (4) wait_frame_end(400);
        mode = 2;
        wait_falls(2, 400);
        scan_en = 1'b0;
        wait_frame_end(400);
        check("ch5_cmd", 32'(last_cmd), 32'h1D);
        check("ch5_val", 32'(vals[5]), 57);
        check("ch4_kept", 32'(vals[4]), 43);
        check("ch6_kept", 32'(vals[6]), 63);
        falls_before = n_cs_fall;
        repeat (400) @(negedge SYS_CLK);
        #1;
        check("stop_no_frames", 32'(n_cs_fall), 32'(falls_before));
        check("stop_cs_n", 32'(ADC_CS_N), 32'h7);

        // Reset during period 12 of ch6
        scan_en = 1'b1;
        wait_falls(11, 400);
        @(negedge SYS_CLK);
        #2;
        SYS_RST_N = 1'b0;
        #1;
        check("midrst_cs_n", 32'(ADC_CS_N), 32'h7);
        check("midrst_sclk", 32'(ADC_SCLK), 0);
        check("midrst_mosi", 32'(ADC_MOSI), 0);
        check("midrst_adc5", 32'(vals[5]), 0);
        check("midrst_adc0", 32'(vals[0]), 0);
        check("midrst_done", 32'(scan_done), 0);
        repeat (3) @(negedge SYS_CLK);
        SYS_RST_N = 1'b1;
        wait_frame_end(400);
        check("restart_cs", 32'(last_cs), 32'h6);
        check("restart_cmd", 32'(last_cmd), 32'h18);
        check("restart_val0", 32'(vals[0]), 7);
        check("restart_val6", 32'(vals[6]), 0);

        check("mosi_stable_sclk_high", 32'(viol_mosi), 0);
        check("cs_onehot", 32'(viol_cs), 0);
        check("val_change_gap_only", 32'(viol_val), 0);
        check("done_on_gap_entry", 32'(viol_done), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
